alu_regs_dp: RTL and testbench
==============================

# alu_regs_dp

Parametrised register-file-plus-ALU datapath: the successor to the fixed 8-bit, four-register, four-function ALU and register pair. A sequencer accepts one operation per handshake, reads two source registers, executes, and writes back to a destination register while updating a flag register. The block sits between the front-panel or controller stimulus and any downstream display or bus logic.

## Interface
- WIDTH, 8: data path and register width in bits; minimum 4.
- NREGS, 4: number of registers; power of two, minimum 2.
- SELW, $clog2(NREGS): register-select width; derived, never overridden.
- ck  in  1  clock; all state changes on the rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- func  in  4  operation code, latched with start.
- sa, sb, sd  in  SELW each  source A, source B and destination register selects; latched with start.
- imm  in  WIDTH  immediate for LDI; latched with start.
- busy  out  1  high from the cycle after acceptance through WB.
- done  out  1  one-cycle pulse in WB.
- err  out  1  valid with done; high for an illegal func.
- result  out  WIDTH  registered ALU result; holds its value until the next EXEC completes.
- flags  out  4  {N,Z,C,V}.
- dbg_sel  in  SELW / dbg_data  out  WIDTH  combinational read of R[dbg_sel], for bench visibility.

## Operation
- States: IDLE, READ, EXEC, WB, plus MULT when MUL_EN is defined.
- IDLE→READ: start=1. Latch func, sa, sb, sd and imm.
- READ→EXEC: latch A=R[sa] and B=R[sb].
- EXEC→WB: register the result.
- WB→IDLE: write R[sd] and flags on this edge unless err. done=1 throughout WB.
- func codes:
  - 0 PASSA
  - 1 OR
  - 2 AND
  - 3 ADD (A+B)
  - 4 SUB (A−B)
  - 5 XOR
  - 6 ADC (A+B+C)
  - 7 LDI (result=imm)
  - 8 MUL (MUL_EN only)
  - Any other code is illegal: no write, flags unchanged, result unchanged, err=1.
- Arithmetic is modulo 2^WIDTH.
  - C is the carry out for ADD and ADC.
  - For SUB, C=1 means no borrow.
  - V is signed overflow for ADD, SUB and ADC.
- Logic ops and PASSA clear C and V and update Z and N.
- LDI writes imm and leaves all flags unchanged.
- sa=sb and sd=sa are legal. Operands are the values before the write.
- start while busy is ignored and not queued.
- When clr_n is asserted, reset is immediate and holds while asserted:
  - all registers 0
  - flags 0, result 0
  - busy 0, done 0, err 0
  - state IDLE
- An operation in flight when reset asserts is discarded with no write.

## Timing
- start high at edge k → busy=1 after k.
- WB is active between edges k+3 and k+4, with done=1 there. Commit happens at edge k+4. busy=0 after k+4.
- Latency is 4 cycles; the earliest next acceptance is edge k+4.
- MUL inserts WIDTH cycles of MULT between EXEC and WB, giving a latency of 4+WIDTH.
- dbg_data shows the new value the cycle after commit.

## Configuration
- ALU_REGS_MUL_EN defined:
  - func 8 is unsigned shift-add multiply, one partial product per cycle in MULT.
  - result is the low WIDTH bits.
  - C=V=1 if the high half is nonzero; Z and N are taken from the low half.
- ALU_REGS_MUL_EN undefined: func 8 is illegal, the MULT state is absent, and there is no multiplier logic.

## Structure
- Package alu_regs_pkg holds:
  - the func_e enum
  - the state_e enum
  - flag bit-index constants FLG_N, FLG_Z, FLG_C, FLG_V
- Sub-module alu_regs_core: the combinational ALU (A, B, cin, func → result, flags, illegal), covering funcs 0–7.
- The top level holds the register array, the FSM and the MULT datapath.

## Test plan
All scenarios use WIDTH=8, NREGS=4.
- Reset, then dbg-read all registers → every register reads 0; flags=0; busy=0.
- LDI sd=1 imm=0x7F, LDI sd=2 imm=0x01, ADD sa=1 sb=2 sd=3 → R3=0x80, flags N=1 Z=0 C=0 V=1, done exactly 4 cycles after each start.
- SUB on 0x05−0x05 into R0 → R0=0x00, Z=1, C=1, V=0. Then ADC of 0xFF+0x00 with C=1 → 0x00, C=1, Z=1.
- func=0xF → done with err=1, no register change, flags unchanged. A start pulse during busy → ignored, with exactly one done.
- clr_n pulsed low during EXEC of ADD sd=2 → R2=0, no done, IDLE. The next start is accepted normally.
- With ALU_REGS_MUL_EN: 0x10×0x11 → result 0x10, C=V=1, latency 12. Without the macro the same op → err=1.

Source files
------------

// File: rtl/alu_regs_pkg.sv
// Shared types and flag indices for the alu_regs_dp datapath.
// The MULT state only exists when ALU_REGS_MUL_EN is defined.
package alu_regs_pkg;

  typedef enum logic [3:0] {
    F_PASSA = 4'd0,
    F_OR    = 4'd1,
    F_AND   = 4'd2,
    F_ADD   = 4'd3,
    F_SUB   = 4'd4,
    F_XOR   = 4'd5,
    F_ADC   = 4'd6,
    F_LDI   = 4'd7,
    F_MUL   = 4'd8
  } func_e;

`ifdef ALU_REGS_MUL_EN
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB, ST_MULT} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_e;
`endif

  // Bit positions inside the {N,Z,C,V} flag word.
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_regs_core.sv
// Combinational ALU for funcs 0-7; every other code is reported as illegal.
// LDI returns operand b, so the caller steers the immediate onto b.
module alu_regs_core
  import alu_regs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       func,
  input  logic [3:0]       flags_in,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags_out,
  output logic             illegal
);

  logic [WIDTH:0] sum;
  logic           arith;
  logic           same_sign;

  always_comb begin
    sum       = '0;
    res       = '0;
    illegal   = 1'b0;
    arith     = 1'b0;
    same_sign = 1'b0;
    flags_out = flags_in;
    case (func)
      F_PASSA: res = a;
      F_OR:    res = a | b;
      F_AND:   res = a & b;
      F_XOR:   res = a ^ b;
      F_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        arith = 1'b1;
      end
      // Subtract as a + ~b + 1 so the carry out means "no borrow".
      F_SUB: begin
        sum   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        arith = 1'b1;
      end
      F_ADC: begin
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        arith = 1'b1;
      end
      F_LDI:   res = b;
      default: illegal = 1'b1;
    endcase
    if (arith) res = sum[WIDTH-1:0];
    same_sign = (func == F_SUB) ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1]);
    if (!illegal && func != F_LDI) begin
      flags_out[FLG_N] = res[WIDTH-1];
      flags_out[FLG_Z] = (res == '0);
      flags_out[FLG_C] = arith & sum[WIDTH];
      flags_out[FLG_V] = arith & same_sign & (res[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_regs_dp.sv
// Register file + ALU sequencer: IDLE -> READ -> EXEC [-> MULT] -> WB.
// Optional shift-add multiplier (func 8) enabled by defining ALU_REGS_MUL_EN.
module alu_regs_dp
  import alu_regs_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic             ck,
  input  logic             clr_n,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [SELW-1:0]  sa,
  input  logic [SELW-1:0]  sb,
  input  logic [SELW-1:0]  sd,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  input  logic [SELW-1:0]  dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state, state_n;
  logic             rd_phase;
  logic [3:0]       func_q;
  logic [SELW-1:0]  sa_q, sb_q, sd_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q, result_q;
  logic [3:0]       flags_q, pend_flags;
  logic             err_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [WIDTH-1:0] alu_b, alu_res;
  logic [3:0]       alu_flags;
  logic             alu_ill;

  assign alu_b = (func_q == F_LDI) ? imm_q : b_q;

  alu_regs_core #(.WIDTH(WIDTH)) u_core (
    .a         (a_q),
    .b         (alu_b),
    .cin       (flags_q[FLG_C]),
    .func      (func_q),
    .flags_in  (flags_q),
    .res       (alu_res),
    .flags_out (alu_flags),
    .illegal   (alu_ill)
  );

`ifdef ALU_REGS_MUL_EN
  localparam int CNTW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] acc, mcand, acc_n;
  logic [WIDTH-1:0]   mplier;
  logic [CNTW-1:0]    cnt;
  logic               mul_last, mul_hi;
  logic [3:0]         mul_flags;

  assign acc_n     = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (cnt == CNTW'(WIDTH-1));
  assign mul_hi    = |acc_n[2*WIDTH-1:WIDTH];
  assign mul_flags = {acc_n[WIDTH-1], acc_n[WIDTH-1:0] == '0, mul_hi, mul_hi};
`endif

  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // READ spends two cycles (rd_phase) so commit lands four edges after acceptance.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_READ;
      ST_READ: if (rd_phase) state_n = ST_EXEC;
`ifdef ALU_REGS_MUL_EN
      ST_EXEC: state_n = (func_q == F_MUL) ? ST_MULT : ST_WB;
      ST_MULT: if (mul_last) state_n = ST_WB;
`else
      ST_EXEC: state_n = ST_WB;
`endif
      ST_WB:   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) begin
      rd_phase   <= 1'b0;
      func_q     <= '0;
      sa_q       <= '0;
      sb_q       <= '0;
      sd_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      pend_flags <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef ALU_REGS_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      rd_phase <= (state == ST_READ) && !rd_phase;
      case (state)
        ST_IDLE: if (start) begin
          func_q <= func;
          sa_q   <= sa;
          sb_q   <= sb;
          sd_q   <= sd;
          imm_q  <= imm;
        end
        ST_READ: if (rd_phase) begin
          a_q <= regs[sa_q];
          b_q <= regs[sb_q];
        end
        ST_EXEC: begin
`ifdef ALU_REGS_MUL_EN
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a_q};
          mplier <= b_q;
          cnt    <= '0;
          if (func_q != F_MUL) begin
`else
          begin
`endif
            if (!alu_ill) result_q <= alu_res;
            pend_flags <= alu_flags;
            err_q      <= alu_ill;
          end
        end
`ifdef ALU_REGS_MUL_EN
        ST_MULT: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNTW'(1);
          if (mul_last) begin
            result_q   <= acc_n[WIDTH-1:0];
            pend_flags <= mul_flags;
            err_q      <= 1'b0;
          end
        end
`endif
        ST_WB: if (!err_q) begin
          regs[sd_q] <= result_q;
          flags_q    <= pend_flags;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_WB);
  assign err      = done & err_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_alu_regs_dp.sv
// Scoreboard bench for alu_regs_dp (WIDTH=8, NREGS=4); expectations come from a bench-side model.
// Define ALU_REGS_MUL_EN for both bench and RTL to exercise the multiplier.
module tb_alu_regs_dp;

  logic       ck = 1'b0, clr_n = 1'b0, start = 1'b0;
  logic [3:0] func = '0;
  logic [1:0] sa = '0, sb = '0, sd = '0, dbg_sel = '0;
  logic [7:0] imm = '0;
  logic       busy, done, err;
  logic [7:0] result, dbg_data;
  logic [3:0] flags;

  typedef struct {logic [7:0] res; logic [7:0] rv; logic [3:0] flg; logic err; int lat; int sd;} exp_t;
  typedef struct {int f; int a; int b; int d; int im;} op_t;

  exp_t       sbq[$];
  logic [7:0] mr[4];
  logic [3:0] mflags;
  logic [7:0] mresult;
  int         n_cmp = 0, n_bad = 0, done_cnt = 0;

  alu_regs_dp #(.WIDTH(8), .NREGS(4)) dut (
    .ck(ck), .clr_n(clr_n), .start(start), .func(func), .sa(sa), .sb(sb), .sd(sd),
    .imm(imm), .busy(busy), .done(done), .err(err), .result(result), .flags(flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 ck = ~ck;
  always @(negedge ck) if (done) done_cnt++;

  function automatic void model(input int f, input int a, input int b, input int im,
                                input logic [3:0] fl, output logic [7:0] r,
                                output logic [3:0] nf, output logic e);
    int full, sres, sa_i, sb_i, cflag;
    bit arith, mul;
    full = 0; sres = 0; arith = 0; mul = 0; e = 0; nf = fl;
    sa_i = (a >= 128) ? a - 256 : a;
    sb_i = (b >= 128) ? b - 256 : b;
    cflag = fl[1] ? 1 : 0;
    case (f)
      0: full = a;
      1: full = a | b;
      2: full = a & b;
      5: full = a ^ b;
      3: begin full = a + b;         sres = sa_i + sb_i;         arith = 1; end
      4: begin full = a - b;         sres = sa_i - sb_i;         arith = 1; end
      6: begin full = a + b + cflag; sres = sa_i + sb_i + cflag; arith = 1; end
      7: full = im;
`ifdef ALU_REGS_MUL_EN
      8: begin full = a * b; mul = 1; end
`endif
      default: e = 1;
    endcase
    r = full[7:0];
    if (!e && f != 7) begin
      nf[3] = r[7];
      nf[2] = (r == 8'h00);
      if (arith) begin
        nf[1] = (f == 4) ? (a >= b) : (full > 255);
        nf[0] = (sres > 127) || (sres < -128);
      end else begin
        nf[1] = mul && (full > 255);
        nf[0] = mul && (full > 255);
      end
    end
  endfunction

  task automatic issue(input int f, input int a_sel, input int b_sel, input int d_sel, input int im);
    exp_t x;
    logic [7:0] r;
    logic [3:0] nf;
    logic e;
    model(f, int'(mr[a_sel]), int'(mr[b_sel]), im, mflags, r, nf, e);
    if (!e) begin
      mr[d_sel] = r;
      mflags    = nf;
      mresult   = r;
    end
    x.res = mresult; x.rv = mr[d_sel]; x.flg = mflags; x.err = e; x.sd = d_sel;
    x.lat = (f == 8 && !e) ? 12 : 4;
    sbq.push_back(x);
    @(negedge ck);
    func = 4'(f); sa = 2'(a_sel); sb = 2'(b_sel); sd = 2'(d_sel); imm = 8'(im); start = 1'b1;
    @(negedge ck);
    start = 1'b0;
  endtask

  // Waits for done with a cycle budget, samples WB outputs, then steps past the commit edge.
  task automatic finish_op(output int lat, output logic e, output logic [7:0] res);
    lat = 1; e = 1'b0; res = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge ck);
      lat++;
      @(negedge ck);
      start = 1'b0;
    end
    e = err; res = result;
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(negedge ck);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_flags got %h want 0", flags); end
    n_cmp++; if (result !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_result got %h want 0", result); end
    clr_n = 1'b1;
    @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_R%0d got %h want 00", i, dbg_data); end
    end
    foreach (mr[i]) mr[i] = 8'h00;
    mflags = 4'h0; mresult = 8'h00;
  endtask

  task automatic run_table(input string name, input op_t ops[$]);
    exp_t x; int lat; logic e; logic [7:0] res;
    foreach (ops[i]) begin
      issue(ops[i].f, ops[i].a, ops[i].b, ops[i].d, ops[i].im);
      finish_op(lat, e, res);
      x = sbq.pop_front();
      dbg_sel = 2'(x.sd); #1;
      n_cmp++; if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL %s[%0d] latency got %0d want %0d", name, i, lat, x.lat); end
      n_cmp++; if (e !== x.err) begin n_bad++; $display("[TB] FAIL %s[%0d] err got %b want %b", name, i, e, x.err); end
      n_cmp++; if (res !== x.res) begin n_bad++; $display("[TB] FAIL %s[%0d] result got %h want %h", name, i, res, x.res); end
      n_cmp++; if (dbg_data !== x.rv) begin n_bad++; $display("[TB] FAIL %s[%0d] R%0d got %h want %h", name, i, x.sd, dbg_data, x.rv); end
      n_cmp++; if (flags !== x.flg) begin n_bad++; $display("[TB] FAIL %s[%0d] flags got %b want %b", name, i, flags, x.flg); end
    end
  endtask

  task automatic test_add_overflow();
    op_t ops[$];
    ops = '{'{7, 0, 0, 1, 8'h7F}, '{7, 0, 0, 2, 8'h01}, '{3, 1, 2, 3, 0}};
    run_table("add_ovf", ops);
    dbg_sel = 2'd3; #1;
    n_cmp++; if (dbg_data !== 8'h80) begin n_bad++; $display("[TB] FAIL add_ovf_R3 got %h want 80", dbg_data); end
    n_cmp++; if (flags !== 4'b1001) begin n_bad++; $display("[TB] FAIL add_ovf_flags got %b want 1001", flags); end
  endtask

  task automatic test_sub_adc();
    op_t ops[$];
    ops = '{'{7, 0, 0, 0, 8'h05}, '{4, 0, 0, 0, 0}, '{7, 0, 0, 1, 8'hFF}, '{6, 1, 0, 2, 0}};
    run_table("sub_adc", ops);
    dbg_sel = 2'd2; #1;
    n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL adc_R2 got %h want 00", dbg_data); end
    n_cmp++; if (flags !== 4'b0110) begin n_bad++; $display("[TB] FAIL adc_flags got %b want 0110", flags); end
  endtask

  task automatic test_mixed();
    op_t ops[$];
    ops = '{'{7, 0, 0, 0, 8'hC3}, '{7, 0, 0, 1, 8'h5A}, '{1, 0, 1, 2, 0}, '{2, 0, 1, 3, 0},
            '{5, 0, 0, 3, 0}, '{0, 1, 0, 2, 0}};
    for (int i = 0; i < 6; i++)
      ops.push_back('{int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255))});
    run_table("mixed", ops);
  endtask

  task automatic test_illegal_and_busy();
    op_t ops[$];
    logic [3:0] fl_before;
    fl_before = mflags;
    ops = '{'{15, 1, 2, 3, 8'h44}};
    run_table("illegal", ops);
    n_cmp++; if (flags !== fl_before) begin n_bad++; $display("[TB] FAIL illegal_flags got %b want %b", flags, fl_before); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++; if (dbg_data !== mr[i]) begin n_bad++; $display("[TB] FAIL illegal_R%0d got %h want %h", i, dbg_data, mr[i]); end
    end
    // Second request raised while busy must be dropped: one done, R0 untouched.
    done_cnt = 0;
    issue(3, 1, 2, 3, 0);
    func = 4'd7; sd = 2'd0; imm = 8'hAA; start = 1'b1;
    ops = '{};
    run_table_tail("busy");
    repeat (6) @(negedge ck);
    dbg_sel = 2'd0; #1;
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL busy_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL busy_idle got %b want 0", busy); end
    n_cmp++; if (dbg_data !== mr[0]) begin n_bad++; $display("[TB] FAIL busy_R0 got %h want %h", dbg_data, mr[0]); end
  endtask

  // Completes an operation that was already issued by the caller.
  task automatic run_table_tail(input string name);
    exp_t x; int lat; logic e; logic [7:0] res;
    finish_op(lat, e, res);
    x = sbq.pop_front();
    dbg_sel = 2'(x.sd); #1;
    n_cmp++; if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL %s latency got %0d want %0d", name, lat, x.lat); end
    n_cmp++; if (res !== x.res) begin n_bad++; $display("[TB] FAIL %s result got %h want %h", name, res, x.res); end
    n_cmp++; if (dbg_data !== x.rv) begin n_bad++; $display("[TB] FAIL %s R%0d got %h want %h", name, x.sd, dbg_data, x.rv); end
  endtask

  task automatic test_reset_midop();
    op_t ops[$];
    ops = '{'{7, 0, 0, 2, 8'h5A}, '{7, 0, 0, 1, 8'h21}};
    run_table("pre_rst", ops);
    done_cnt = 0;
    @(negedge ck);
    func = 4'd3; sa = 2'd1; sb = 2'd1; sd = 2'd2; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    repeat (2) @(negedge ck);
    clr_n = 1'b0;
    @(negedge ck);
    clr_n = 1'b1;
    repeat (6) @(negedge ck);
    dbg_sel = 2'd2; #1;
    n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL midrst_R2 got %h want 00", dbg_data); end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("[TB] FAIL midrst_done_count got %0d want 0", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("[TB] FAIL midrst_flags got %b want 0000", flags); end
    foreach (mr[i]) mr[i] = 8'h00;
    mflags = 4'h0; mresult = 8'h00;
    ops = '{'{7, 0, 0, 2, 8'h33}};
    run_table("post_rst", ops);
  endtask

  task automatic test_mul();
    op_t ops[$];
    ops = '{'{7, 0, 0, 0, 8'h10}, '{7, 0, 0, 1, 8'h11}, '{8, 0, 1, 3, 0}};
    run_table("mul", ops);
`ifdef ALU_REGS_MUL_EN
    n_cmp++; if (flags !== 4'b0011) begin n_bad++; $display("[TB] FAIL mul_flags got %b want 0011", flags); end
`else
    dbg_sel = 2'd3; #1;
    n_cmp++; if (dbg_data !== mr[3]) begin n_bad++; $display("[TB] FAIL mul_disabled_R3 got %h want %h", dbg_data, mr[3]); end
`endif
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_adc();
    test_mixed();
    test_illegal_and_busy();
    test_reset_midop();
    test_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
